// File: rtl/cy7c_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// cy7c_rst_seq_pkg
//
// Shared definitions for the CY7C67200 reset sequencer:
//   - FSM state encodings (enum plus plain logic constants)
//   - Avalon-MM register addresses
//   - bit positions inside CTRL and STATUS
//   - down-counter width and the counter load helper
//
// No ports; imported by cy7c67200_reset_sequencer.
// -----------------------------------------------------------------------------
package cy7c_rst_seq_pkg;

  // Width of the PULSE/BOOT registers and of the down-counter.
  localparam int CNT_W = 16;

  // FSM state encodings. The enum documents the encoding for anyone decoding
  // STATUS[3:2]; the RTL uses the plain logic constants below.
  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_PULSE = 2'd1,
    STATE_BOOT  = 2'd2,
    STATE_HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_BOOT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Register addresses.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_BOOT   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_HOLD_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // STATUS bit positions.
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_STATE_LSB = 2;

  // Counter load value for a programmed length: max(len,1)-1. A length of 0
  // is treated as 1 so a phase never collapses to zero cycles.
  function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] len);
    if (len == '0) begin
      return '0;
    end
    return len - 1'b1;
  endfunction

endpackage

// File: rtl/cy7c67200_reset_sequencer.sv
// -----------------------------------------------------------------------------
// cy7c67200_reset_sequencer
//
// Generates the RESET_N pulse for a CY7C67200 USB controller and then waits a
// programmable boot time before reporting completion. After reset is released
// one power-on sequence runs automatically; software can start further
// sequences through CTRL.START or park the chip in reset with CTRL.HOLD.
//
// Sequence: PULSE (out_port=0 for max(PULSE,1) cycles)
//           -> BOOT (out_port=1 for max(BOOT,1) cycles)
//           -> IDLE, DONE set.
//
// Parameters:
//   PULSE_DEF  reset value of PULSE register (clk cycles)
//   BOOT_DEF   reset value of BOOT register (clk cycles)
//
// Ports:
//   clk        single clock
//   reset      synchronous active-high reset
//   address    Avalon-MM register select (0 CTRL, 1 PULSE, 2 BOOT, 3 STATUS)
//   chipselect Avalon-MM select
//   write_n    Avalon-MM write strobe, active-low
//   writedata  Avalon-MM write data
//   readdata   zero-wait-state combinational read data
//   out_port   registered RESET_N to the chip (0 = chip held in reset)
//   busy       high while in PULSE or BOOT
//   irq        completion interrupt
//
// Build option:
//   CY7C_RST_SEQ_IRQ_EN  when defined, CTRL.IRQ_EN exists and irq=DONE&IRQ_EN;
//                        when undefined, irq is tied to 0 and CTRL bit2 reads 0.
// -----------------------------------------------------------------------------
module cy7c67200_reset_sequencer
  import cy7c_rst_seq_pkg::*;
#(
  parameter logic [15:0] PULSE_DEF = 16'd500,
  parameter logic [15:0] BOOT_DEF  = 16'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        busy,
  output logic        irq
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] boot_q,  boot_d;
  logic             hold_q,  hold_d;
  logic             done_q,  done_d;
  logic             out_q,   out_d;

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic wr_ctrl;
  logic wr_pulse;
  logic wr_boot;
  logic wr_status;
  logic start_req;
  logic done_set;
  logic done_clr;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en & (address == ADDR_CTRL);
  assign wr_pulse  = wr_en & (address == ADDR_PULSE);
  assign wr_boot   = wr_en & (address == ADDR_BOOT);
  assign wr_status = wr_en & (address == ADDR_STATUS);

  // START is a pulse that exists only during the write cycle; it is never
  // stored, so it cannot linger and fire a later sequence.
  assign start_req = wr_ctrl & writedata[CTRL_START_BIT];
  assign done_clr  = wr_status & writedata[STAT_DONE_BIT];

  // ---------------------------------------------------------------------------
  // Register file (PULSE, BOOT, HOLD, optional IRQ_EN)
  // ---------------------------------------------------------------------------
  always_comb begin
    pulse_d = pulse_q;
    boot_d  = boot_q;
    hold_d  = hold_q;
    if (wr_pulse) begin
      pulse_d = writedata[CNT_W-1:0];
    end
    if (wr_boot) begin
      boot_d = writedata[CNT_W-1:0];
    end
    if (wr_ctrl) begin
      hold_d = writedata[CTRL_HOLD_BIT];
    end
  end

`ifdef CY7C_RST_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end

  assign irq = done_q & irq_en_q;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:CNT_W];
`else
  assign irq = 1'b0;

  // Bit 2 of CTRL has no storage in this build.
  logic unused_wdata;
  assign unused_wdata = ^{writedata[31:CNT_W], writedata[CTRL_IRQ_EN_BIT]};
`endif

  // ---------------------------------------------------------------------------
  // FSM and down-counter
  // ---------------------------------------------------------------------------
  // hold_d is the HOLD value that will be in effect after this edge, so a CTRL
  // write that sets HOLD moves the FSM to HOLD on the write edge itself and
  // takes precedence over a START carried in the same write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_PULSE;
          cnt_d   = load_value(pulse_q);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_BOOT;
          cnt_d   = load_value(boot_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BOOT: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        // Leaving HOLD never restarts a sequence on its own.
        if (!hold_d) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // HOLD aborts whatever was running and suppresses completion.
    if (hold_d) begin
      state_d  = ST_HOLD;
      cnt_d    = cnt_q;
      done_set = 1'b0;
    end
  end

  // DONE is sticky; a completion on the same edge as a W1C wins.
  always_comb begin
    done_d = done_q;
    if (done_clr) begin
      done_d = 1'b0;
    end
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  // out_port is computed from the next state so the pin changes on the same
  // edge as the state, without a combinational path to the pad.
  always_comb begin
    out_d = ~((state_d == ST_PULSE) || (state_d == ST_HOLD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PULSE;
      cnt_q   <= load_value(PULSE_DEF);
      pulse_q <= PULSE_DEF;
      boot_q  <= BOOT_DEF;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      boot_q  <= boot_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign out_port = out_q;
  assign busy     = (state_q == ST_PULSE) || (state_q == ST_BOOT);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_HOLD_BIT] = hold_q;
`ifdef CY7C_RST_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
      end
      ADDR_PULSE: begin
        readdata[CNT_W-1:0] = pulse_q;
      end
      ADDR_BOOT: begin
        readdata[CNT_W-1:0] = boot_q;
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT]                    = busy;
        readdata[STAT_DONE_BIT]                    = done_q;
        readdata[STAT_STATE_LSB+1:STAT_STATE_LSB]  = state_q;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

endmodule
